riscv_data_memory: RTL and testbench
====================================

Name: riscv_data_memory

Overview:
Byte-addressed, little-endian data memory for the RV32I 5-stage pipeline. It is driven directly by the cpu MEM stage.
- Loads are combinational: result valid in the same cycle as addr/mem_ctrl.
- Stores commit on the rising clock edge.
- Supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW), with sign or zero extension on loads.

Parameters:
MEM_SIZE_BYTES, 1024, storage depth in bytes; power of two, minimum 4.

Ports:
clk  in  1  rising-edge clock.
resetn  in  1  asynchronous active-low reset.
wr_en  in  1  store strobe; sampled at posedge clk.
mem_ctrl  in  mem_op_t  access width and signedness.
addr  in  32  byte address.
data_in  in  32  store data; low bits are used for SB/SH.
data_out  out  32  load result; combinational.

Behaviour:
- Storage: array named mem, MEM_SIZE_BYTES entries of 8 bits, index = byte address. It is hierarchically accessible so benches can preload and inspect it.
- Contents are not cleared by reset and are not initialised by RTL.
- Effective address: ea = addr mod MEM_SIZE_BYTES (low log2(MEM_SIZE_BYTES) bits). Upper bits are ignored.
- Multi-byte accesses wrap byte-by-byte: byte k uses (ea+k) mod MEM_SIZE_BYTES.
- Byte order is little-endian: the byte at ea is bits [7:0].
- Misaligned H/W accesses are performed byte-wise with no fault.
- Load, combinational:
  - MEM_LB: sign-extend mem[ea].
  - MEM_LBU: zero-extend mem[ea].
  - MEM_LH: sign-extend {mem[ea+1], mem[ea]}.
  - MEM_LHU: zero-extend the same halfword.
  - MEM_LW: {mem[ea+3], mem[ea+2], mem[ea+1], mem[ea]}.
  - Store encodings and MEM_NONE: data_out = the word at ea, as for MEM_LW.
- data_out is never X for in-range storage.
- Store, at posedge clk when wr_en=1 and resetn=1:
  - MEM_SB: writes data_in[7:0] to ea.
  - MEM_SH: writes data_in[15:0] to ea, ea+1.
  - MEM_SW: writes data_in[31:0] to ea..ea+3.
  - wr_en=1 with a load encoding or MEM_NONE: no write.
- A read of the same address in the same cycle as a store returns the old data; the new data is visible after the edge.
- While resetn=0: all writes are suppressed, data_out remains combinational.
- A reset asserted mid-store, before the edge, cancels that store.
- Outputs at reset: data_out is purely combinational and has no reset value. Optional err output resets to 0.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - Adds output port err (1 bit), registered and asynchronously cleared to 0 by resetn.
  - On posedge, err <= 1 when the current access is misaligned: H access with ea[0]=1, or W access with ea[1:0]!=0. This covers loads, and covers stores only when wr_en=1.
  - Otherwise err <= 0.
  - Misaligned stores are still suppressed when this macro is defined.
- Undefined: no err port; misaligned accesses complete byte-wise as above.

Decomposition:
- control_types_pkg: typedef enum logic [3:0] mem_op_t, with values MEM_NONE=0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
  - Shared with cpu decode and the pipeline registers.
- Sub-module: riscv_load_extend, a pure combinational helper mapping raw word + mem_ctrl to data_out.
- Address wrap and byte-lane writes stay in the top module.

Test Plan:
- SW 0x0000000A at addr 512, wr_en=1, one edge -> mem[512]=0x0a, mem[513..515]=0x00; LW 512 -> 0x0000000A.
- Preload mem[100]=0x80: LB 100 -> 0xFFFFFF80; LBU 100 -> 0x00000080.
- SH data_in=0xDEAD8001 at 200 -> mem[200]=0x01, mem[201]=0x80; LH -> 0xFFFF8001; LHU -> 0x00008001; mem[202] unchanged.
- SW 0x11223344 at addr 1022 (MEM_SIZE_BYTES=1024) -> mem[1022]=0x44, mem[1023]=0x33, mem[0]=0x22, mem[1]=0x11; addr 0x00000400+4 aliases to byte 4.
- Hold resetn=0 with SW 0xFFFFFFFF at 8 across two edges -> mem[8..11] unchanged; release -> next edge writes.
- MISALIGN_CHECK_EN defined:
  - LW at addr 2 -> err=1 after the edge, memory untouched.
  - SW at 6 -> err=1, mem[6..9] unchanged.
  - Aligned LW -> err=0.
  - resetn=0 -> err=0 immediately.

Source files
------------

// File: rtl/control_types_pkg.sv
// rtl/control_types_pkg.sv - memory access encodings shared by decode, pipeline registers and data memory
package control_types_pkg;

    // Width and signedness of a MEM-stage access.
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    // Number of bytes a store encoding writes; 0 for loads and MEM_NONE.
    function automatic logic [2:0] store_bytes(input mem_op_t op);
        case (op)
            MEM_SB:  return 3'd1;
            MEM_SH:  return 3'd2;
            MEM_SW:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_load_extend.sv
// rtl/riscv_load_extend.sv - selects and sign/zero extends the load result from the raw little-endian word
//   raw      in  32        bytes ea..ea+3, byte at ea in [7:0]
//   mem_ctrl in  mem_op_t  access width and signedness
//   data_out out 32        load result
module riscv_load_extend
    import control_types_pkg::*;
(
    input  logic [31:0] raw,
    input  mem_op_t     mem_ctrl,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = raw;
        case (mem_ctrl)
            MEM_LB:  data_out = {{24{raw[7]}}, raw[7:0]};
            MEM_LBU: data_out = {24'h0, raw[7:0]};
            MEM_LH:  data_out = {{16{raw[15]}}, raw[15:0]};
            MEM_LHU: data_out = {16'h0, raw[15:0]};
            // LW, stores and MEM_NONE all present the full word
            default: data_out = raw;
        endcase
    end

endmodule

// File: rtl/riscv_data_memory.sv
// rtl/riscv_data_memory.sv - byte-addressed little-endian RV32I data memory, combinational load, clocked store
//   clk      in  1         rising-edge clock
//   resetn   in  1         asynchronous active-low reset; suppresses stores while low
//   wr_en    in  1         store strobe
//   mem_ctrl in  mem_op_t  access width and signedness
//   addr     in  32        byte address (wrapped modulo MEM_SIZE_BYTES)
//   data_in  in  32        store data
//   data_out out 32        load result, combinational
//   err      out 1         misaligned-access flag, only when MISALIGN_CHECK_EN is defined
module riscv_data_memory
    import control_types_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  mem_op_t     mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int AW = $clog2(MEM_SIZE_BYTES);

    logic [7:0]    mem [MEM_SIZE_BYTES];

    logic [AW-1:0] ea;
    logic [AW-1:0] lane_addr [4];
    logic [3:0]    lane_we;
    logic [2:0]    n_bytes;
    logic          misaligned;
    logic          is_load;
    logic          store_ok;
    logic [31:0]   raw;

    assign ea = addr[AW-1:0];

    // Upper address bits are ignored by design.
    logic unused_addr;
    assign unused_addr = ^addr[31:AW];

    // Each byte lane wraps independently, so a word at the top of memory
    // spills into the bottom bytes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = ea + AW'(k);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        is_load    = 1'b0;
        case (mem_ctrl)
            MEM_LH, MEM_LHU, MEM_SH: misaligned = ea[0];
            MEM_LW, MEM_SW:          misaligned = (ea[1:0] != 2'b00);
            default:                 misaligned = 1'b0;
        endcase
        case (mem_ctrl)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    end

    assign n_bytes = store_bytes(mem_ctrl);

`ifdef MISALIGN_CHECK_EN
    assign store_ok = wr_en && (n_bytes != 3'd0) && !misaligned;
`else
    assign store_ok = wr_en && (n_bytes != 3'd0);
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_we[k] = store_ok && (3'(k) < n_bytes);
        end
    end

    // Storage has no reset; resetn low at the edge simply cancels the store.
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we[k]) begin
                    mem[lane_addr[k]] <= data_in[8*k +: 8];
                end
            end
        end
    end

    assign raw = {mem[lane_addr[3]], mem[lane_addr[2]], mem[lane_addr[1]], mem[lane_addr[0]]};

    riscv_load_extend u_load_extend (
        .raw      (raw),
        .mem_ctrl (mem_ctrl),
        .data_out (data_out)
    );

`ifdef MISALIGN_CHECK_EN
    // Loads flag regardless of wr_en; stores flag only when actually strobed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else begin
            err <= misaligned && (is_load || (wr_en && (n_bytes != 3'd0)));
        end
    end
`else
    logic unused_is_load;
    assign unused_is_load = is_load;
`endif

endmodule

// File: tb/tb_riscv_data_memory.sv
// tb/tb_riscv_data_memory.sv - randomized self-checking bench for riscv_data_memory against a byte-array model
module tb_riscv_data_memory;
    import control_types_pkg::*;

    localparam int MSZ = 1024;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    mem_op_t     mem_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
`ifdef MISALIGN_CHECK_EN
    logic        err;
`endif

    riscv_data_memory #(.MEM_SIZE_BYTES(MSZ)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .mem_ctrl (mem_ctrl),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
`ifdef MISALIGN_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] ref_mem [MSZ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int byte_at(input logic [31:0] a, input int k);
        return int'(ref_mem[(int'(a % MSZ) + k) % MSZ]);
    endfunction

    function automatic logic [31:0] model_load(input mem_op_t op, input logic [31:0] a);
        int v;
        case (op)
            MEM_LB:  begin v = byte_at(a, 0); if (v >= 128) v -= 256; end
            MEM_LBU: v = byte_at(a, 0);
            MEM_LH:  begin v = byte_at(a, 0) + 256 * byte_at(a, 1); if (v >= 32768) v -= 65536; end
            MEM_LHU: v = byte_at(a, 0) + 256 * byte_at(a, 1);
            default: v = byte_at(a, 0) + (byte_at(a, 1) << 8) + (byte_at(a, 2) << 16) + (byte_at(a, 3) << 24);
        endcase
        return 32'(v);
    endfunction

    function automatic bit model_mis(input mem_op_t op, input logic [31:0] a);
        int ea = int'(a % MSZ);
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (ea % 2) != 0;
        if (op == MEM_LW || op == MEM_SW) return (ea % 4) != 0;
        return 1'b0;
    endfunction

    function automatic bit model_err(input mem_op_t op, input logic [31:0] a, input logic we);
        bit is_ld = (op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU);
        bit is_st = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
        return model_mis(op, a) && (is_ld || (is_st && we));
    endfunction

    task automatic model_store(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
        int n;
        case (op)
            MEM_SB:  n = 1;
            MEM_SH:  n = 2;
            MEM_SW:  n = 4;
            default: n = 0;
        endcase
`ifdef MISALIGN_CHECK_EN
        if (model_mis(op, a)) n = 0;
`endif
        for (int k = 0; k < n; k++) ref_mem[(int'(a % MSZ) + k) % MSZ] = d[8*k +: 8];
    endtask

    // Called just after a negedge; checks the combinational read, then the edge.
    task automatic cycle(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input string tag);
        logic rst_at_edge;
        bit   exp_err;
        mem_ctrl = op;
        addr     = a;
        data_in  = d;
        wr_en    = we;
        #1;
        check({tag, "_rd"}, data_out, model_load(op, a));
        exp_err = model_err(op, a, we);
        @(posedge clk);
        rst_at_edge = resetn;
        if (rst_at_edge && we) model_store(op, a, d);
        #1;
`ifdef MISALIGN_CHECK_EN
        check({tag, "_err"}, {31'b0, err}, {31'b0, rst_at_edge && exp_err});
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        resetn   = 1'b0;
        wr_en    = 1'b0;
        mem_ctrl = MEM_NONE;
        addr     = 32'h0;
        data_in  = 32'h0;
        for (int i = 0; i < MSZ; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            dut.mem[i] = v;
        end
        ref_mem[100] = 8'h80; dut.mem[100] = 8'h80;
        ref_mem[202] = 8'h5a; dut.mem[202] = 8'h5a;
        repeat (2) @(negedge clk);

        // Reset state: reads stay combinational, err cleared
        mem_ctrl = MEM_LW; addr = 32'd100;
        #1;
        check("rst_rd", data_out, model_load(MEM_LW, 32'd100));
`ifdef MISALIGN_CHECK_EN
        check("rst_err", {31'b0, err}, 32'h0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        // SW then LW at 512
        cycle(MEM_SW, 32'd512, 32'h0000000A, 1'b1, "sw512");
        check("m512", {24'h0, dut.mem[512]}, 32'h0a);
        check("m513", {24'h0, dut.mem[513]}, 32'h00);
        check("m515", {24'h0, dut.mem[515]}, 32'h00);
        cycle(MEM_LW, 32'd512, 32'h0, 1'b0, "lw512");
        mem_ctrl = MEM_LW; #1;
        check("lw512_val", data_out, 32'h0000000A);
        @(negedge clk);

        // Sign/zero extension of a byte
        mem_ctrl = MEM_LB; addr = 32'd100; #1;
        check("lb100", data_out, 32'hFFFFFF80);
        mem_ctrl = MEM_LBU; #1;
        check("lbu100", data_out, 32'h00000080);
        @(negedge clk);

        // Halfword store and loads
        cycle(MEM_SH, 32'd200, 32'hDEAD8001, 1'b1, "sh200");
        check("m200", {24'h0, dut.mem[200]}, 32'h01);
        check("m201", {24'h0, dut.mem[201]}, 32'h80);
        check("m202", {24'h0, dut.mem[202]}, 32'h5a);
        mem_ctrl = MEM_LH; addr = 32'd200; #1;
        check("lh200", data_out, 32'hFFFF8001);
        mem_ctrl = MEM_LHU; #1;
        check("lhu200", data_out, 32'h00008001);
        @(negedge clk);

        // Wrap across the top of memory, then alias above MSZ
        cycle(MEM_SW, 32'd1022, 32'h11223344, 1'b1, "sw1022");
        check("m1022", {24'h0, dut.mem[1022]}, 32'h44);
        check("m1023", {24'h0, dut.mem[1023]}, 32'h33);
        check("m0", {24'h0, dut.mem[0]}, 32'h22);
        check("m1", {24'h0, dut.mem[1]}, 32'h11);
        cycle(MEM_SB, 32'h00000404, 32'h00000077, 1'b1, "sb404");
        check("m4_alias", {24'h0, dut.mem[4]}, 32'h77);

        // Store held off by reset across two edges, then committed
        for (int i = 8; i < 12; i++) begin ref_mem[i] = 8'h00; dut.mem[i] = 8'h00; end
        resetn = 1'b0;
        cycle(MEM_SW, 32'd8, 32'hFFFFFFFF, 1'b1, "sw8_rst0");
        cycle(MEM_SW, 32'd8, 32'hFFFFFFFF, 1'b1, "sw8_rst1");
        check("m8_held", {24'h0, dut.mem[8]}, 32'h00);
        check("m11_held", {24'h0, dut.mem[11]}, 32'h00);
        resetn = 1'b1;
        cycle(MEM_SW, 32'd8, 32'hFFFFFFFF, 1'b1, "sw8_go");
        check("m8_wr", {24'h0, dut.mem[8]}, 32'hff);
        check("m11_wr", {24'h0, dut.mem[11]}, 32'hff);

        // Reset asserted mid-cycle cancels the pending store
        mem_ctrl = MEM_SW; addr = 32'd16; data_in = 32'hA5A5A5A5; wr_en = 1'b1;
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        check("m16_cancel", {24'h0, dut.mem[16]}, {24'h0, ref_mem[16]});
        @(negedge clk);
        resetn = 1'b1;

`ifdef MISALIGN_CHECK_EN
        cycle(MEM_LW, 32'd2, 32'h0, 1'b0, "lw2_mis");
        check("lw2_errflag", {31'b0, err}, 32'h1);
        cycle(MEM_SW, 32'd6, 32'hCAFEBABE, 1'b1, "sw6_mis");
        for (int i = 6; i < 10; i++) check("m6_keep", {24'h0, dut.mem[i]}, {24'h0, ref_mem[i]});
        resetn = 1'b0; #1;
        check("err_async_clr", {31'b0, err}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cycle(MEM_LW, 32'd12, 32'h0, 1'b0, "lw12_ok");
`endif

        // Randomized traffic, biased toward the wrap boundary
        for (int n = 0; n < 400; n++) begin
            mem_op_t     op = mem_op_t'($urandom_range(0, 8));
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) a = 32'(MSZ - 4 + $urandom_range(0, 7)) + (32'($urandom_range(0, 7)) << 10);
            else a = $urandom;
            cycle(op, a, $urandom, 1'($urandom_range(0, 1)), "rnd");
        end

        for (int i = 0; i < MSZ; i++) check("mem_final", {24'h0, dut.mem[i]}, {24'h0, ref_mem[i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
